// File: rtl/rc4_keystream_xor.sv
// RC4 keystream consumer: buffers 4-bit keystream nibbles in a FIFO and XORs each
// with one plaintext nibble into a registered valid/ready output stage.
module rc4_keystream_xor #(
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     ks_valid,
    input  logic [3:0]               ks_data,
    output logic                     ks_ready,
    input  logic                     pt_valid,
    input  logic [3:0]               pt_data,
    output logic                     pt_ready,
    output logic                     ct_valid,
    output logic [3:0]               ct_data,
    input  logic                     ct_ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [CW-1:0]            nib_count,
    output logic                     ks_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [3:0]    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          ct_valid_q, ct_valid_d;
    logic [3:0]    ct_data_q, ct_data_d;
    logic [CW-1:0] nib_count_q, nib_count_d;
    logic          ks_overflow_q, ks_overflow_d;

    logic full, empty, out_free, push, fire, handshake;
    logic [3:0] fifo_head;

    // Wrap bits differ but indices match: writer is one lap ahead of the reader.
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign fill      = wr_ptr_q - rd_ptr_q;
    assign fifo_head = mem_q[rd_ptr_q[AW-1:0]];

    assign ks_ready  = !full;
    assign out_free  = !ct_valid_q || ct_ready;
    assign pt_ready  = !empty && out_free;
    assign handshake = ct_valid_q && ct_ready;
    assign push      = ks_valid && ks_ready && !flush;
    assign fire      = pt_valid && pt_ready && !flush;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        ct_valid_d    = ct_valid_q;
        ct_data_d     = ct_data_q;
        nib_count_d   = handshake ? nib_count_q + CNT_ONE : nib_count_q;
        ks_overflow_d = ks_overflow_q || (ks_valid && !ks_ready);

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            ct_valid_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (fire) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                ct_data_d  = pt_data ^ fifo_head;
                ct_valid_d = 1'b1;
            end else if (handshake) begin
                ct_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ct_valid_q    <= 1'b0;
            ct_data_q     <= '0;
            nib_count_q   <= '0;
            ks_overflow_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ct_valid_q    <= ct_valid_d;
            ct_data_q     <= ct_data_d;
            nib_count_q   <= nib_count_d;
            ks_overflow_q <= ks_overflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; entries are only read behind the
    // write pointer, so reset values would cost flops without changing behaviour.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= ks_data;
    end

    assign ct_valid    = ct_valid_q;
    assign ct_data     = ct_data_q;
    assign nib_count   = nib_count_q;
    assign ks_overflow = ks_overflow_q;

endmodule
